ts_bus_sampler: RTL
===================

# ts_bus_sampler

Receive-side end of the tristate lane bus. The block samples the per-lane drive enables and data produced by the bus-driving generator every clock. It keeps a bus-keeper image of each lane's last driven value, and queues one record per cycle in which any lane is driven. Downstream logic or the testbench drains the records through a valid/ready interface. The block sits beside the bus model as its consumer, and is the checker/reader counterpart of the data generator.

## Interface
Parameters:
- LANES, 4, number of tristate lanes
- DEPTH, 8, record FIFO depth; power of two, ≥2
- STAMP_W, 4, width of the free-running cycle stamp

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- drive  in  LANES  lane i is driven this cycle
- d  in  LANES  lane data; meaningful only where drive[i]=1
- keep  out  LANES  bus-keeper value per lane
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_drive  out  LANES  head record drive mask
- rec_data  out  LANES  head record data, d & drive (undriven bits read 0)
- rec_stamp  out  STAMP_W  head record cycle stamp (0 when stamping compiled out)
- count  out  $clog2(DEPTH)+1  records held, 0..DEPTH
- overflow  out  1  sticky: a record was dropped
- clear  in  1  synchronous clear of overflow

## Operation
- Sample event: posedge with |drive = 1. Push {drive, d & drive, stamp}.
- Cycles with drive = 0 produce no record.
- keep: at each posedge, keep[i] <= d[i] where drive[i]; otherwise hold.
- Stamp counter: increments every posedge and wraps 2^STAMP_W−1 → 0. A record carries the counter value before the increment at the sampling edge.
- FIFO: circular buffer with read/write pointers and an occupancy counter.
  - Pop = rec_valid & rec_ready.
  - Push when full and no pop in the same cycle: record dropped, count unchanged, overflow set.
  - Push and pop together while full: both take effect, count stays DEPTH, no overflow.
  - Push and pop together while count = 1: count stays 1, and the new record becomes the head.
- rec_valid = (count != 0). rec_* are driven from the head entry and stay stable while rec_valid & !rec_ready.
- overflow: set by a drop and cleared by clear. If clear and a drop occur in the same cycle, overflow ends the cycle at 1 (set wins).
- Reset mid-operation: FIFO contents are discarded (count → 0) and in-flight records are lost without an overflow indication.

## Timing
- Reset values:
  - keep = 0
  - rec_valid = 0, rec_drive = 0, rec_data = 0, rec_stamp = 0
  - count = 0, overflow = 0
  - internal stamp counter = 0
- Latency: a sample at edge N gives rec_valid = 1 after edge N, i.e. it is visible in cycle N+1 when the FIFO was empty.
- keep reflects the lane value one cycle after it is driven.
- Pop latency is 0. The next record is presented in the cycle after the accepting edge.
- Throughput: one push and one pop per cycle.
- rec_ready may be asserted at any time; it is ignored while rec_valid = 0.

## Configuration
- TS_BUS_SAMPLER_STAMP_EN defined: the stamp counter and the stamp FIFO field are built, and rec_stamp carries the sampling cycle.
- TS_BUS_SAMPLER_STAMP_EN undefined: no counter and no stamp storage; rec_stamp is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then generator schedule: drive=0010, d=1110 sampled at stamp 1, with drive=0 on all other cycles. Required:
  - exactly one record: rec_drive=0010, rec_data=0010, rec_stamp=1 (0 without the macro)
  - keep=0010 from the following cycle, and it holds 0010 after drive returns to 0
- Hold rec_ready=0 while pushing 9 records with DEPTH=8. Required: count=8, overflow=1, and draining returns records 1..8 in order with record 9 lost. Then assert clear for one cycle: overflow=0.
- With the FIFO full, drive a push and a pop in the same cycle. Required: count stays 8, overflow stays 0, head advances by one, and the new record appears last.
- With count=1, drive a push and a pop in the same cycle. Required: count stays 1, rec_valid stays 1, and the head now holds the new record.
- Push once per cycle for 20 cycles with rec_ready=1 and the macro defined. Required: stamps run 0..15 then 0..3 (wrap), and count never exceeds 1.
- Assert rst_n low asynchronously while count=5 and keep=1011. Required: immediately count=0, rec_valid=0, keep=0000, overflow=0.

Source files
------------

// File: rtl/ts_bus_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ts_bus_sampler_if
//  Description : Lane bus (drive enables + data) and the record stream
//                (valid/ready with drive/data/stamp payload) between the
//                tristate lane bus, the sampler and its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ts_bus_sampler_if #(
    parameter int LANES   = 4,
    parameter int STAMP_W = 4
);
    logic [LANES-1:0]   drive;
    logic [LANES-1:0]   d;
    logic               rec_valid;
    logic               rec_ready;
    logic [LANES-1:0]   rec_drive;
    logic [LANES-1:0]   rec_data;
    logic [STAMP_W-1:0] rec_stamp;

    // Sampler side: reads the lanes, produces records.
    modport master (
        input  drive, d, rec_ready,
        output rec_valid, rec_drive, rec_data, rec_stamp
    );

    // Generator/consumer side: drives the lanes, drains records.
    modport slave (
        output drive, d, rec_ready,
        input  rec_valid, rec_drive, rec_data, rec_stamp
    );
endinterface
`default_nettype wire

// File: rtl/ts_bus_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ts_bus_sampler
//  Description : Receive end of the tristate lane bus. Keeps a bus-keeper
//                image of every lane and queues one record per cycle in which
//                any lane is driven; records drain through valid/ready.
//                Optional feature macro TS_BUS_SAMPLER_STAMP_EN builds the
//                free-running cycle stamp and its FIFO field; without it
//                rec_stamp is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_bus_sampler #(
    parameter int LANES   = 4,
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ts_bus_sampler_if.master        bus,
    output logic [LANES-1:0]        keep,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clear
);
    localparam int                 c_ADDR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);

    logic [LANES-1:0]    r_mem_drive [0:DEPTH-1];
    logic [LANES-1:0]    r_mem_data  [0:DEPTH-1];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [LANES-1:0]    r_keep;

    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr_en;
    logic w_drop;

    // A record exists whenever any lane is driven; a full FIFO only accepts
    // it if the head leaves in the same cycle, otherwise it is dropped.
    assign w_valid = (r_count != '0);
    assign w_push  = |bus.drive;
    assign w_pop   = w_valid & bus.rec_ready;
    assign w_full  = (r_count == c_FULL);
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Bus keeper: each lane remembers the last value driven onto it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keep <= '0;
        end else begin
            r_keep <= (r_keep & ~bus.drive) | (bus.d & bus.drive);
        end
    end

    // Record storage; contents are don't-care until covered by the count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_drive[r_wr_ptr] <= bus.drive;
            r_mem_data[r_wr_ptr]  <= bus.d & bus.drive;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef TS_BUS_SAMPLER_STAMP_EN
    logic [STAMP_W-1:0] r_stamp;
    logic [STAMP_W-1:0] r_mem_stamp [0:DEPTH-1];

    // Free-running cycle stamp; a record takes the pre-increment value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    // Stamp field of the record storage, written alongside drive/data.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_stamp[r_wr_ptr] <= r_stamp;
        end
    end

    assign bus.rec_stamp = w_valid ? r_mem_stamp[r_rd_ptr] : '0;
`else
    assign bus.rec_stamp = '0;
`endif

    // Head record is presented straight from storage; zero when empty.
    assign bus.rec_valid = w_valid;
    assign bus.rec_drive = w_valid ? r_mem_drive[r_rd_ptr] : '0;
    assign bus.rec_data  = w_valid ? r_mem_data[r_rd_ptr]  : '0;

    assign keep     = r_keep;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
